// File: rtl/imem_xbar_pkg.sv
// Shared decode helpers and return-path tag for the banked instruction crossbar.
package imem_xbar_pkg;

    localparam int unsigned TAG_BANK_W = 8;

    // Per-CPU record of what was granted last cycle, used to steer returned data.
    typedef struct packed {
        logic                  valid;
        logic [TAG_BANK_W-1:0] bank;
        logic                  oob;
    } ret_tag_t;

    // Bank index for a word address under either mapping.
    function automatic logic [31:0] decode_bank(input logic [31:0] addr,
                                                input int unsigned num_banks,
                                                input int unsigned depth,
                                                input bit interleave);
        if (interleave) return addr % num_banks;
        return addr / depth;
    endfunction

    // Word offset inside the selected bank under either mapping.
    function automatic logic [31:0] decode_offset(input logic [31:0] addr,
                                                  input int unsigned num_banks,
                                                  input int unsigned depth,
                                                  input bit interleave);
        if (interleave) return addr / num_banks;
        return addr % depth;
    endfunction

    // Address beyond the populated memory.
    function automatic logic is_oob(input logic [31:0] addr,
                                    input int unsigned num_banks,
                                    input int unsigned depth);
        return addr >= 32'(num_banks * depth);
    endfunction

endpackage

// File: rtl/banked_imem_xbar_rr_arbiter.sv
// Round-robin arbiter: one-hot combinational grant, pointer advances past the winner.
module rr_arbiter #(
    parameter int unsigned N = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    output logic [N-1:0] gnt_c
);

    localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr;
    logic [PW-1:0] win;
    logic          found;

    // Search from ptr for the first active requester; no grant while in reset.
    always_comb begin
        gnt_c = '0;
        win   = ptr;
        found = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (!found && req[PW'((32'(ptr) + i) % N)]) begin
                found = 1'b1;
                win   = PW'((32'(ptr) + i) % N);
            end
        end
        for (int unsigned j = 0; j < N; j++) begin
            if (found && !rst && (win == PW'(j))) gnt_c[j] = 1'b1;
        end
    end

    // Pointer moves to winner+1 only when something was granted.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (found) begin
            ptr <= (win == PW'(N - 1)) ? '0 : win + PW'(1);
        end
    end

endmodule

// File: rtl/banked_imem_xbar.sv
// Read-only CPU-to-bank crossbar with per-bank round-robin arbitration.
module banked_imem_xbar import imem_xbar_pkg::*; #(
    parameter int unsigned NUM_CPUS   = 3,
    parameter int unsigned NUM_BANKS  = 3,
    parameter int unsigned BANK_DEPTH = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned INTERLEAVE = 0,
    parameter int unsigned CNT_W      = 16,
    localparam int unsigned BANK_AW   = $clog2(BANK_DEPTH),
    localparam int unsigned ADDR_W    = $clog2(BANK_DEPTH * NUM_BANKS)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_CPUS-1:0]           req_cpu,
    input  logic [NUM_CPUS*ADDR_W-1:0]    addr_cpu,
    output logic [NUM_CPUS-1:0]           gnt_cpu,
    output logic [NUM_CPUS-1:0]           rvalid_cpu,
    output logic [NUM_CPUS*DATA_W-1:0]    rdata_cpu,
    output logic [NUM_CPUS-1:0]           err_cpu,
    output logic [NUM_CPUS*CNT_W-1:0]     stall_cnt_cpu,
    output logic [NUM_BANKS-1:0]          re_bank,
    output logic [NUM_BANKS*BANK_AW-1:0]  ra_bank,
    input  logic [NUM_BANKS*DATA_W-1:0]   rd_bank
);

    logic [NUM_CPUS-1:0]                  cpu_oob;
    logic [TAG_BANK_W-1:0]                cpu_bank [NUM_CPUS];
    logic [BANK_AW-1:0]                   cpu_off  [NUM_CPUS];
    logic [NUM_BANKS-1:0][NUM_CPUS-1:0]   bank_req;
    logic [NUM_BANKS-1:0][NUM_CPUS-1:0]   bank_gnt;
    logic [NUM_BANKS*BANK_AW-1:0]         ra_q;
    ret_tag_t                             tag_q [NUM_CPUS];

    // Address decode per CPU.
    for (genvar c = 0; c < NUM_CPUS; c++) begin : g_dec
        logic [31:0] a;
        assign a           = 32'(addr_cpu[c*ADDR_W +: ADDR_W]);
        assign cpu_oob[c]  = is_oob(a, NUM_BANKS, BANK_DEPTH);
        assign cpu_bank[c] = TAG_BANK_W'(decode_bank(a, NUM_BANKS, BANK_DEPTH, INTERLEAVE != 0));
        assign cpu_off[c]  = BANK_AW'(decode_offset(a, NUM_BANKS, BANK_DEPTH, INTERLEAVE != 0));
    end

    // Requester set of each bank: in-range CPUs that decode to it.
    always_comb begin
        bank_req = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            for (int c = 0; c < NUM_CPUS; c++) begin
                bank_req[b][c] = req_cpu[c] & ~cpu_oob[c] & (cpu_bank[c] == TAG_BANK_W'(b));
            end
        end
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_arb
        rr_arbiter #(.N(NUM_CPUS)) u_arb (
            .clk   (clk),
            .rst   (rst),
            .req   (bank_req[b]),
            .gnt_c (bank_gnt[b])
        );
    end

    // Bank read strobes; the address holds its last value when idle.
    always_comb begin
        re_bank = '0;
        ra_bank = ra_q;
        for (int b = 0; b < NUM_BANKS; b++) begin
            re_bank[b] = |bank_gnt[b];
            for (int c = 0; c < NUM_CPUS; c++) begin
                if (bank_gnt[b][c]) ra_bank[b*BANK_AW +: BANK_AW] = cpu_off[c];
            end
        end
    end

    // Bank address history for the hold behaviour.
    always_ff @(posedge clk) begin
        if (rst) ra_q <= '0;
        else     ra_q <= ra_bank;
    end

    // CPU grants: out-of-range requests pass straight through.
    always_comb begin
        gnt_cpu = req_cpu & cpu_oob;
        for (int b = 0; b < NUM_BANKS; b++) begin
            gnt_cpu = gnt_cpu | bank_gnt[b];
        end
        if (rst) gnt_cpu = '0;
    end

    // Capture what each CPU was granted so the reply can be steered next cycle.
    always_ff @(posedge clk) begin
        for (int c = 0; c < NUM_CPUS; c++) begin
            if (rst) tag_q[c] <= '0;
            else     tag_q[c] <= {gnt_cpu[c], cpu_bank[c], cpu_oob[c]};
        end
    end

    // Reply mux; data and error are forced low unless valid, and dropped during reset.
    always_comb begin
        rvalid_cpu = '0;
        err_cpu    = '0;
        rdata_cpu  = '0;
        for (int c = 0; c < NUM_CPUS; c++) begin
            if (tag_q[c].valid && !rst) begin
                rvalid_cpu[c] = 1'b1;
                err_cpu[c]    = tag_q[c].oob;
                for (int b = 0; b < NUM_BANKS; b++) begin
                    if (!tag_q[c].oob && (tag_q[c].bank == TAG_BANK_W'(b))) begin
                        rdata_cpu[c*DATA_W +: DATA_W] = rd_bank[b*DATA_W +: DATA_W];
                    end
                end
            end
        end
    end

    // Saturating per-CPU stall counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_cpu <= '0;
        end else begin
            for (int c = 0; c < NUM_CPUS; c++) begin
                if (req_cpu[c] && !gnt_cpu[c] && (stall_cnt_cpu[c*CNT_W +: CNT_W] != '1)) begin
                    stall_cnt_cpu[c*CNT_W +: CNT_W] <= stall_cnt_cpu[c*CNT_W +: CNT_W] + CNT_W'(1);
                end
            end
        end
    end

endmodule
